uart_mem_loader: RTL
====================

// Module: uart_mem_loader
// PURPOSE
//  Upstream stage of the 32-bit single-port on-chip RAM (32768 words, 1-cycle sync write, byte enables).
//  Accepts a byte stream from the UART receiver and packs 4 bytes little-endian into 32-bit words.
//  Writes each word through the RAM's Avalon slave port, auto-incrementing the address.
//  Partial words are flushed with matching byteenable on end-of-transfer or inter-byte timeout.
// PARAMETERS
//  ADDR_W      15      RAM word-address width
//  DEPTH       32768   RAM depth in words; address wraps DEPTH-1 -> 0
//  TIMEOUT     50000   idle clk cycles with a partial word pending before forced flush
//  CNT_W       16      width of word-count / timeout counters
// PORTS
//  clk             in   1       system clock
//  reset           in   1       asynchronous, active-high reset
//  start           in   1       1-cycle pulse: begin load; ignored unless IDLE
//  base_addr       in   ADDR_W  first word address, sampled on start
//  num_words       in   CNT_W   words to load, sampled on start; 0 = unbounded (timeout ends)
//  abort           in   1       1-cycle pulse: flush pending partial word, then DONE
//  rx_data         in   8       received byte
//  rx_valid        in   1       rx_data valid
//  rx_ready        out  1       byte accepted when rx_valid & rx_ready
//  mem_address     out  ADDR_W  RAM word address
//  mem_byteenable  out  4       RAM byte lanes
//  mem_chipselect  out  1       RAM select
//  mem_write       out  1       RAM write strobe
//  mem_writedata   out  32      RAM write data
//  mem_clken       out  1       RAM clock enable; constant 1 out of reset
//  busy            out  1       high in COLLECT/WRITE
//  done            out  1       1-cycle pulse on completion
//  words_written   out  CNT_W   words (incl. partial) committed since start
// BEHAVIOUR
//  Reset values: rx_ready=0, mem_chipselect=0, mem_write=0, mem_byteenable=0, mem_writedata=0,
//   mem_address=0, mem_clken=1, busy=0, done=0, words_written=0; FSM=IDLE; lane counter=0.
//  FSM: IDLE -(start)-> COLLECT; COLLECT -(4th byte | flush)-> WRITE; WRITE -> COLLECT or DONE; DONE -> IDLE.
//  IDLE: rx_ready=0; on start latch base_addr->addr, num_words, clear words_written, lane=0.
//  COLLECT: rx_ready=1; accepted byte goes to lane[lane], byte k -> writedata[8k+7:8k]; lane++.
//   Accepting lane 3 -> WRITE next cycle with byteenable=4'b1111.
//  Flush trigger (COLLECT, lane>0): timeout counter reaches TIMEOUT-1 with no accepted byte, or abort.
//   -> WRITE with byteenable = (1<<lane)-1; unused lanes of writedata = 0.
//  abort or timeout with lane==0: go straight to DONE, no write.
//  WRITE: exactly one cycle: chipselect=1, write=1, address=addr; rx_ready=0 (byte held off).
//   Next: addr = (addr==DEPTH-1) ? 0 : addr+1; words_written++; lane=0.
//   -> DONE if num_words!=0 and words_written (post-increment)==num_words, or a flush/abort caused it; else COLLECT.
//  DONE: done=1 for one cycle, busy=0, -> IDLE.
//  Timeout counter: cleared on every accepted byte and on entering COLLECT; counts only when lane>0.
//  abort simultaneous with byte accept: byte is accepted first, then flush includes it.
//  abort outside COLLECT: ignored. start while busy: ignored.
//  Latency: last byte accepted in cycle N -> mem_write high in cycle N+1; one write per 4 bytes.
//  Back-to-back bytes: max sustained rate 4 bytes / 5 cycles (WRITE stalls rx_ready).
//  Reset mid-operation: all state cleared immediately; partial word discarded; no write issued.
//  words_written saturates at all-ones (no wrap).
// STRUCTURE
//  Shared package: FSM state enum {IDLE,COLLECT,WRITE,DONE}, lane-to-byteenable table, ADDR_W/DEPTH defaults.
//  One sub-module natural: uart_mem_loader_timeout (clear, enable, terminal-count pulse).
//  Byte packer, address counter and FSM remain in the top module.
// TESTING
//  start base=0x0010,num=2; bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211@0x0010, 0x88776655@0x0011 be=F; done pulse; words_written=2.
//  start base=0x7FFF,num=2; 8 bytes -> second write at 0x0000 (wrap); done.
//  start num=0; bytes AA BB then idle TIMEOUT cycles -> write 0x0000BBAA be=4'b0011; done; words_written=1.
//  start num=0; bytes 01 02 03 with abort on 3rd accept cycle -> write 0x00030201 be=4'b0111; done.
//  Reset asserted after 2 bytes -> no mem_write, all outputs at reset values; new start works normally.
//  rx_valid held high continuously, num=3 -> rx_ready low only in WRITE cycles; 12 bytes in 15 cycles.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the UART-to-RAM loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   Contents: FSM state enum, default geometry/timeout values,
//   lane-fill-count to Avalon byteenable helper.
package uart_mem_loader_pkg;

   localparam int ADDR_W_DEF  = 15;
   localparam int DEPTH_DEF   = 32768;
   localparam int TIMEOUT_DEF = 50000;
   localparam int CNT_W_DEF   = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Number of filled byte lanes (0..4) -> byteenable covering the low lanes.
   function automatic logic [3:0] fill_to_be(input logic [2:0] filled);
      logic [3:0] be;
      case (filled)
         3'd1:    be = 4'b0001;
         3'd2:    be = 4'b0011;
         3'd3:    be = 4'b0111;
         3'd4:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/uart_mem_loader_timeout.sv
`timescale 1ns/1ps
// Inter-byte idle timer: flags TIMEOUT consecutive enabled cycles without a clear.
// Latency: tc is combinational from the count register (asserted in the TIMEOUT-th enabled cycle).
// Backpressure: none; clear has priority over enable.
//   Ports: clk, reset (async active-high), clear, enable -> tc (terminal-count pulse).
module uart_mem_loader_timeout
   import uart_mem_loader_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
      end
   end

   assign tc = enable && (cnt == TERM);

endmodule

// File: rtl/uart_mem_loader.sv
`timescale 1ns/1ps
// Packs a UART byte stream little-endian into 32-bit words and writes them to RAM via Avalon.
// Latency: last byte of a word accepted in cycle N -> mem_write high in cycle N+1.
// Backpressure: rx_ready drops for the single WRITE cycle (sustained 4 bytes / 5 cycles).
//   Ports: control (start, base_addr, num_words, abort), byte stream (rx_data/rx_valid/rx_ready),
//   RAM Avalon slave side (mem_*), status (busy, done, words_written).
module uart_mem_loader
   import uart_mem_loader_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   input  logic              abort,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  words_written
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   state_t           state;
   logic [1:0]       lane;
   logic [CNT_W-1:0] num_r;
   logic             end_after;   // current WRITE was caused by a flush/abort

   logic             accept;
   logic [2:0]       filled;
   logic             tc;
   logic             flush;
   logic [CNT_W-1:0] ww_inc;
   logic             last_word;
   logic [ADDR_W-1:0] addr_nxt;

   assign mem_clken = 1'b1;

   assign accept    = rx_valid & rx_ready;
   assign filled    = {1'b0, lane} + {2'b00, accept};
   // A byte landing in the terminal cycle restarts the idle window instead of flushing.
   assign flush     = abort | (tc & ~accept);
   assign ww_inc    = (words_written == '1) ? words_written : words_written + 1'b1;
   assign last_word = (num_r != '0) && (ww_inc == num_r);
   assign addr_nxt  = (mem_address == ADDR_LAST) ? '0 : mem_address + 1'b1;

   // Idle time only matters while a partial word is pending; an empty word never times out.
   uart_mem_loader_timeout #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  ((state != ST_COLLECT) | accept),
      .enable ((state == ST_COLLECT) && (lane != 2'd0)),
      .tc     (tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         lane           <= 2'd0;
         num_r          <= '0;
         end_after      <= 1'b0;
         rx_ready       <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= 4'b0000;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         words_written  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mem_address   <= base_addr;
                  num_r         <= num_words;
                  words_written <= '0;
                  lane          <= 2'd0;
                  mem_writedata <= '0;
                  end_after     <= 1'b0;
                  rx_ready      <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_COLLECT;
               end
            end

            ST_COLLECT: begin
               if (accept) begin
                  mem_writedata[{lane, 3'b000} +: 8] <= rx_data;
               end
               if (accept && lane == 2'd3) begin
                  // Full word; an abort in the same cycle still ends the load after it.
                  mem_byteenable <= 4'b1111;
                  mem_chipselect <= 1'b1;
                  mem_write      <= 1'b1;
                  rx_ready       <= 1'b0;
                  end_after      <= abort;
                  state          <= ST_WRITE;
               end else if (flush) begin
                  rx_ready <= 1'b0;
                  if (filled == 3'd0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     mem_byteenable <= fill_to_be(filled);
                     mem_chipselect <= 1'b1;
                     mem_write      <= 1'b1;
                     end_after      <= 1'b1;
                     state          <= ST_WRITE;
                  end
               end else if (accept) begin
                  lane <= lane + 2'd1;
               end
            end

            ST_WRITE: begin
               mem_byteenable <= 4'b0000;
               mem_chipselect <= 1'b0;
               mem_write      <= 1'b0;
               mem_writedata  <= '0;   // next word starts with unused lanes at zero
               mem_address    <= addr_nxt;
               words_written  <= ww_inc;
               lane           <= 2'd0;
               if (end_after || last_word) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  rx_ready <= 1'b1;
                  state    <= ST_COLLECT;
               end
            end

            ST_DONE: begin
               done      <= 1'b0;
               end_after <= 1'b0;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
